control_fsm: RTL and testbench

//  Multicycle RV32I main control FSM. Sequences fetch/decode/execute/mem/writeback

---
 rtl/control_fsm_if.sv | 34 +++
 rtl/control_fsm.sv | 248 ++++++++++++++++++++++++
 tb/tb_control_fsm.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// Datapath <-> control handshake bundle: IR fields and compare flags in, datapath strobes/selects out.
// The master modport is the control FSM; the slave modport is the datapath and memory side.
interface control_fsm_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       br_eq;
  logic       br_lt;
  logic       br_ltu;
  logic       mem_ready;

  logic       mem_read;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_ctrl;
  logic       illegal;

  modport master (
    input  opcode, func3, br_eq, br_lt, br_ltu, mem_ready,
    output mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
    output alu_src_a, alu_src_b, result_src, alu_ctrl, illegal
  );

  modport slave (
    output opcode, func3, br_eq, br_lt, br_ltu, mem_ready,
    input  mem_read, mem_write, adr_src, ir_write, pc_write, reg_write,
    input  alu_src_a, alu_src_b, result_src, alu_ctrl, illegal
  );
endinterface

// File: rtl/control_fsm.sv
// Multicycle RV32I control FSM; no-wait latency ALU 4, load 5, store 4, branch 3, JAL 4, JALR 5, trap 3.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready. CTRL_PERF_CNT_EN adds cycle/instret counters.
module control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  control_fsm_if.master    bus,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;
  localparam logic [1:0] A_ZERO  = 2'b11;
  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;
  localparam logic [1:0] R_ALUOUT = 2'b00;
  localparam logic [1:0] R_MEM    = 2'b01;
  localparam logic [1:0] R_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_JALR,
    S_JAL,
    S_BRANCH,
    S_LUI,
    S_AUIPC,
    S_TRAP
  } state_t;

  state_t state_q;

  function automatic state_t decode_next(input logic [6:0] op);
    state_t nxt;
    case (op)
      OPC_LOAD, OPC_STORE: nxt = S_MEMADR;
      OPC_OP:              nxt = S_EXECR;
      OPC_OP_IMM:          nxt = S_EXECI;
      OPC_JAL:             nxt = S_JAL;
      OPC_JALR:            nxt = S_JALR;
      OPC_BRANCH:          nxt = S_BRANCH;
      OPC_LUI:             nxt = S_LUI;
      OPC_AUIPC:           nxt = S_AUIPC;
      default:             nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
    logic t;
    case (f3)
      3'b000:  t = eq;
      3'b001:  t = !eq;
      3'b100:  t = lt;
      3'b101:  t = !lt;
      3'b110:  t = ltu;
      3'b111:  t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: state_q <= decode_next(bus.opcode);
        S_MEMADR: state_q <= bus.opcode[5] ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.mem_ready) state_q <= S_MEMWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_MEMWR:  if (bus.mem_ready) state_q <= S_FETCH;
        S_EXECR:  state_q <= S_ALUWB;
        S_EXECI:  state_q <= S_ALUWB;
        S_ALUWB:  state_q <= S_FETCH;
        S_JALR:   state_q <= S_JAL;
        S_JAL:    state_q <= S_ALUWB;
        S_BRANCH: state_q <= S_FETCH;
        S_LUI:    state_q <= S_ALUWB;
        S_AUIPC:  state_q <= S_ALUWB;
        S_TRAP:   state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  logic       mem_read_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c;
  logic       reg_write_c, alu_ctrl_c, illegal_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;

  always_comb begin
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    alu_ctrl_c   = 1'b0;
    illegal_c    = 1'b0;
    alu_src_a_c  = A_PC;
    alu_src_b_c  = B_RS2;
    result_src_c = R_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        // PC+4 goes straight from the ALU to PC in the same cycle the IR loads.
        if (bus.mem_ready) begin
          ir_write_c   = 1'b1;
          pc_write_c   = 1'b1;
          alu_src_a_c  = A_PC;
          alu_src_b_c  = B_FOUR;
          result_src_c = R_ALU;
        end
      end
      S_DECODE: begin
        alu_src_a_c = A_OLDPC;
        alu_src_b_c = B_IMM;
      end
      S_MEMADR: begin
        alu_src_a_c = A_RS1;
        alu_src_b_c = B_IMM;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        adr_src_c  = 1'b1;
      end
      S_MEMWB: begin
        result_src_c = R_MEM;
        reg_write_c  = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_c = A_RS1;
        alu_src_b_c = B_RS2;
        alu_ctrl_c  = 1'b1;
      end
      S_EXECI: begin
        alu_src_a_c = A_RS1;
        alu_src_b_c = B_IMM;
        alu_ctrl_c  = 1'b1;
      end
      S_ALUWB: begin
        result_src_c = R_ALUOUT;
        reg_write_c  = 1'b1;
      end
      S_JALR: begin
        alu_src_a_c = A_RS1;
        alu_src_b_c = B_IMM;
      end
      S_JAL: begin
        // Target already sits in ALUOut; ALU computes the link value for ALUWB.
        alu_src_a_c  = A_OLDPC;
        alu_src_b_c  = B_FOUR;
        result_src_c = R_ALUOUT;
        pc_write_c   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c  = A_RS1;
        alu_src_b_c  = B_RS2;
        result_src_c = R_ALUOUT;
        pc_write_c   = branch_taken(bus.func3, bus.br_eq, bus.br_lt, bus.br_ltu);
      end
      S_LUI: begin
        alu_src_a_c = A_ZERO;
        alu_src_b_c = B_IMM;
      end
      S_AUIPC: begin
        alu_src_a_c = A_OLDPC;
        alu_src_b_c = B_IMM;
      end
      S_TRAP: begin
        illegal_c = 1'b1;
      end
      default: begin
        illegal_c = 1'b0;
      end
    endcase
  end

  // Reset gates outputs combinationally so an in-flight write dies in the same cycle.
  assign bus.mem_read   = rst_n & mem_read_c;
  assign bus.mem_write  = rst_n & mem_write_c;
  assign bus.adr_src    = rst_n & adr_src_c;
  assign bus.ir_write   = rst_n & ir_write_c;
  assign bus.pc_write   = rst_n & pc_write_c;
  assign bus.reg_write  = rst_n & reg_write_c;
  assign bus.alu_ctrl   = rst_n & alu_ctrl_c;
  assign bus.illegal    = rst_n & illegal_c;
  assign bus.alu_src_a  = rst_n ? alu_src_a_c  : 2'b00;
  assign bus.alu_src_b  = rst_n ? alu_src_b_c  : 2'b00;
  assign bus.result_src = rst_n ? result_src_c : 2'b00;

`ifdef CTRL_PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                  (state_q == S_BRANCH) || (state_q == S_TRAP) ||
                  ((state_q == S_MEMWR) && bus.mem_ready);

  assign cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
  assign instret_cnt_d = retire ? instret_cnt_q + CNT_W'(1) : instret_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench: per-cycle expected control words go into a scoreboard queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_control_fsm;
  localparam int CNT_W = 4;

  // {mem_read, mem_write, adr_src, ir_write, pc_write, reg_write, A[2], B[2], R[2], alu_ctrl, illegal}
  localparam logic [13:0] E_IDLE    = 14'b0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [13:0] E_FETCH_W = 14'b1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [13:0] E_FETCH_R = 14'b1_0_0_1_1_0_00_10_10_0_0;
  localparam logic [13:0] E_DECODE  = 14'b0_0_0_0_0_0_01_01_00_0_0;
  localparam logic [13:0] E_MEMADR  = 14'b0_0_0_0_0_0_10_01_00_0_0;
  localparam logic [13:0] E_MEMRD   = 14'b1_0_1_0_0_0_00_00_00_0_0;
  localparam logic [13:0] E_MEMWB   = 14'b0_0_0_0_0_1_00_00_01_0_0;
  localparam logic [13:0] E_MEMWR   = 14'b0_1_1_0_0_0_00_00_00_0_0;
  localparam logic [13:0] E_EXECR   = 14'b0_0_0_0_0_0_10_00_00_1_0;
  localparam logic [13:0] E_EXECI   = 14'b0_0_0_0_0_0_10_01_00_1_0;
  localparam logic [13:0] E_ALUWB   = 14'b0_0_0_0_0_1_00_00_00_0_0;
  localparam logic [13:0] E_JALR    = 14'b0_0_0_0_0_0_10_01_00_0_0;
  localparam logic [13:0] E_JAL     = 14'b0_0_0_0_1_0_01_10_00_0_0;
  localparam logic [13:0] E_BR_NT   = 14'b0_0_0_0_0_0_10_00_00_0_0;
  localparam logic [13:0] E_BR_T    = 14'b0_0_0_0_1_0_10_00_00_0_0;
  localparam logic [13:0] E_LUI     = 14'b0_0_0_0_0_0_11_01_00_0_0;
  localparam logic [13:0] E_AUIPC   = 14'b0_0_0_0_0_0_01_01_00_0_0;
  localparam logic [13:0] E_TRAP    = 14'b0_0_0_0_0_0_00_00_00_0_1;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  control_fsm_if bus_if ();

  control_fsm #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if.master),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [13:0] exp_q  [$];
  logic [7:0]  cnt_q  [$];
  string       name_q [$];
  int          checks;
  int          errors;
  logic [3:0]  exp_cyc;
  logic [3:0]  exp_ret;

  // Monitor: one control-word and one counter comparison per scoreboard entry.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [13:0] e;
      logic [13:0] got;
      logic [7:0]  ec;
      logic [7:0]  gc;
      string       nm;
      e  = exp_q.pop_front();
      ec = cnt_q.pop_front();
      nm = name_q.pop_front();
      got = {bus_if.mem_read, bus_if.mem_write, bus_if.adr_src, bus_if.ir_write,
             bus_if.pc_write, bus_if.reg_write, bus_if.alu_src_a, bus_if.alu_src_b,
             bus_if.result_src, bus_if.alu_ctrl, bus_if.illegal};
      gc = {cycle_cnt, instret_cnt};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b", nm, got, e);
      end
      checks++;
      if (gc !== ec) begin
        errors++;
        $display("FAIL %s counters got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                 nm, gc[7:4], gc[3:0], ec[7:4], ec[3:0]);
      end
    end
  end

  task automatic cyc(input logic rn, input logic [6:0] op, input logic [2:0] f3,
                     input logic [2:0] br, input logic mr, input logic [13:0] e,
                     input logic ret, input string nm);
    rst_n             = rn;
    bus_if.opcode     = op;
    bus_if.func3      = f3;
    bus_if.br_eq      = br[2];
    bus_if.br_lt      = br[1];
    bus_if.br_ltu     = br[0];
    bus_if.mem_ready  = mr;
    if (!rn) begin
      exp_cyc = '0;
      exp_ret = '0;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
`ifdef CTRL_PERF_CNT_EN
    cnt_q.push_back({exp_cyc, exp_ret});
`else
    cnt_q.push_back(8'h00);
`endif
    if (rn) begin
      exp_cyc = exp_cyc + 4'd1;
      if (ret) exp_ret = exp_ret + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  // Runs FETCH(ready) and DECODE for one instruction.
  task automatic fd(input logic [6:0] op, input logic [2:0] f3, input string nm);
    cyc(1'b1, op, f3, 3'b000, 1'b1, E_FETCH_R, 1'b0, {nm, "_fetch"});
    cyc(1'b1, op, f3, 3'b000, 1'b1, E_DECODE,  1'b0, {nm, "_dec"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cyc = '0;
    exp_ret = '0;
    rst_n   = 1'b0;
    bus_if.opcode = '0; bus_if.func3 = '0; bus_if.mem_ready = 1'b0;
    bus_if.br_eq = 1'b0; bus_if.br_lt = 1'b0; bus_if.br_ltu = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds everything low even with mem_ready asserted.
    cyc(1'b0, OP_R, 3'b000, 3'b000, 1'b1, E_IDLE, 1'b0, "rst0");
    cyc(1'b0, OP_R, 3'b000, 3'b000, 1'b1, E_IDLE, 1'b0, "rst1");

    // ADD x3,x1,x2
    fd(OP_R, 3'b000, "add");
    cyc(1'b1, OP_R, 3'b000, 3'b000, 1'b1, E_EXECR, 1'b0, "add_exec");
    cyc(1'b1, OP_R, 3'b000, 3'b000, 1'b1, E_ALUWB, 1'b1, "add_wb");

    // LW with a fetch stall and three MEMRD wait cycles
    cyc(1'b1, OP_LOAD, 3'b010, 3'b000, 1'b0, E_FETCH_W, 1'b0, "lw_fetch_wait");
    fd(OP_LOAD, 3'b010, "lw");
    cyc(1'b1, OP_LOAD, 3'b010, 3'b000, 1'b1, E_MEMADR, 1'b0, "lw_adr");
    for (int i = 0; i < 3; i++)
      cyc(1'b1, OP_LOAD, 3'b010, 3'b000, 1'b0, E_MEMRD, 1'b0, "lw_rd_wait");
    cyc(1'b1, OP_LOAD, 3'b010, 3'b000, 1'b1, E_MEMRD, 1'b0, "lw_rd_done");
    cyc(1'b1, OP_LOAD, 3'b010, 3'b000, 1'b1, E_MEMWB, 1'b1, "lw_wb");

    // Branch outcomes: {eq,lt,ltu}
    fd(OP_BR, 3'b001, "bne_nt");
    cyc(1'b1, OP_BR, 3'b001, 3'b100, 1'b1, E_BR_NT, 1'b1, "bne_nt_br");
    fd(OP_BR, 3'b001, "bne_t");
    cyc(1'b1, OP_BR, 3'b001, 3'b000, 1'b1, E_BR_T, 1'b1, "bne_t_br");
    fd(OP_BR, 3'b100, "blt_t");
    cyc(1'b1, OP_BR, 3'b100, 3'b010, 1'b1, E_BR_T, 1'b1, "blt_t_br");
    fd(OP_BR, 3'b111, "bgeu_nt");
    cyc(1'b1, OP_BR, 3'b111, 3'b001, 1'b1, E_BR_NT, 1'b1, "bgeu_nt_br");
    fd(OP_BR, 3'b010, "bad_f3");
    cyc(1'b1, OP_BR, 3'b010, 3'b111, 1'b1, E_BR_NT, 1'b1, "bad_f3_br");

    // JALR -> JAL -> ALUWB
    fd(OP_JALR, 3'b000, "jalr");
    cyc(1'b1, OP_JALR, 3'b000, 3'b000, 1'b1, E_JALR,  1'b0, "jalr_adr");
    cyc(1'b1, OP_JALR, 3'b000, 3'b000, 1'b1, E_JAL,   1'b0, "jalr_jal");
    cyc(1'b1, OP_JALR, 3'b000, 3'b000, 1'b1, E_ALUWB, 1'b1, "jalr_wb");

    // SYSTEM opcode traps for one cycle
    fd(OP_SYS, 3'b000, "sys");
    cyc(1'b1, OP_SYS, 3'b000, 3'b000, 1'b1, E_TRAP, 1'b1, "sys_trap");

    // Remaining ALU-writeback paths
    fd(OP_I, 3'b000, "addi");
    cyc(1'b1, OP_I, 3'b000, 3'b000, 1'b1, E_EXECI, 1'b0, "addi_exec");
    cyc(1'b1, OP_I, 3'b000, 3'b000, 1'b1, E_ALUWB, 1'b1, "addi_wb");
    fd(OP_LUI, 3'b000, "lui");
    cyc(1'b1, OP_LUI, 3'b000, 3'b000, 1'b1, E_LUI,   1'b0, "lui_ex");
    cyc(1'b1, OP_LUI, 3'b000, 3'b000, 1'b1, E_ALUWB, 1'b1, "lui_wb");
    fd(OP_AUIPC, 3'b000, "auipc");
    cyc(1'b1, OP_AUIPC, 3'b000, 3'b000, 1'b1, E_AUIPC, 1'b0, "auipc_ex");
    cyc(1'b1, OP_AUIPC, 3'b000, 3'b000, 1'b1, E_ALUWB, 1'b1, "auipc_wb");
    fd(OP_JAL, 3'b000, "jal");
    cyc(1'b1, OP_JAL, 3'b000, 3'b000, 1'b1, E_JAL,   1'b0, "jal_jal");
    cyc(1'b1, OP_JAL, 3'b000, 3'b000, 1'b1, E_ALUWB, 1'b1, "jal_wb");

    // SW completing after one wait
    fd(OP_STORE, 3'b010, "sw");
    cyc(1'b1, OP_STORE, 3'b010, 3'b000, 1'b1, E_MEMADR, 1'b0, "sw_adr");
    cyc(1'b1, OP_STORE, 3'b010, 3'b000, 1'b0, E_MEMWR,  1'b0, "sw_wait");
    cyc(1'b1, OP_STORE, 3'b010, 3'b000, 1'b1, E_MEMWR,  1'b1, "sw_done");

    // SW aborted by reset while mem_write is high
    fd(OP_STORE, 3'b010, "sw_abort");
    cyc(1'b1, OP_STORE, 3'b010, 3'b000, 1'b1, E_MEMADR, 1'b0, "sw_abort_adr");
    cyc(1'b1, OP_STORE, 3'b010, 3'b000, 1'b0, E_MEMWR,  1'b0, "sw_abort_wr");
    cyc(1'b0, OP_STORE, 3'b010, 3'b000, 1'b1, E_IDLE,   1'b0, "sw_abort_rst");
    cyc(1'b1, OP_STORE, 3'b010, 3'b000, 1'b0, E_FETCH_W, 1'b0, "post_rst_fetch");
    cyc(1'b1, OP_STORE, 3'b010, 3'b000, 1'b0, E_FETCH_W, 1'b0, "post_rst_hold");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
